sigadd_pipe: RTL and testbench

SIGADD_PIPE -- requirements
Module: sigadd_pipe

---
 rtl/sigadd_pipe.sv | 191 +++++++++++++++++++
 tb/tb_sigadd_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sigadd_pipe.sv
// -----------------------------------------------------------------------------
// sigadd_pipe -- pipelined signed significand adder/subtractor.
//
// Adds (or subtracts) the aligned significand B, which carries three low
// guard/round/sticky bits, to significand A. Returns the magnitude of the
// result, a zero flag and the sign of the result. Flow control is
// valid/ready. Any output stall freezes the whole pipeline.
//
// Configuration macro:
//   SIGADD_PIPE_ABS_STAGE_EN - when defined, an extra register stage is placed
//                              between the raw sum and the absolute-value logic
//                              (latency 3 instead of 2). The handshake rules are
//                              identical in both builds.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operand set valid
//   in_ready   out  block accepts operands this cycle
//   fa         in   [SIG_W-1:0]   significand A, integer aligned
//   fb         in   [SIG_W+2:0]   aligned significand B, 3 low extension bits
//   sa, sb     in   signs of A and B
//   sub        in   effective-subtract flag
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   fs         out  [SIG_W+3:0]   magnitude of sum
//   fszero     out  sum is exactly zero
//   ss         out  sign of result
// -----------------------------------------------------------------------------
module sigadd_pipe #(
    parameter int SIG_W = 53
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIG_W-1:0] fa,
    input  logic [SIG_W+2:0] fb,
    input  logic             sa,
    input  logic             sb,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIG_W+3:0] fs,
    output logic             fszero,
    output logic             ss
);

    localparam int SUM_W = SIG_W + 5;

    // Magnitude of a two's-complement sum. The magnitude always fits in
    // SUM_W-1 bits, so negation is carried out on the low bits only
    // (conditional invert plus increment).
    function automatic logic [SUM_W-2:0] f_abs(input logic [SUM_W-1:0] v);
        logic [SUM_W-2:0] inv;
        inv = v[SUM_W-2:0] ^ {(SUM_W-1){v[SUM_W-1]}};
        return inv + {{(SUM_W-2){1'b0}}, v[SUM_W-1]};
    endfunction

    logic             w_stall;
    logic [SUM_W-1:0] w_a_ext;
    logic [SUM_W-1:0] w_b_ext;
    logic [SUM_W-1:0] w_sum_in;

    // Stage 1 registers
    logic             r_s1_valid;
    logic [SUM_W-1:0] r_s1_sum;
    logic             r_s1_sa;
    logic             r_s1_sb;
    logic             r_s1_sub;

    // Signals that feed the absolute-value / output stage
    logic             w_pre_valid;
    logic [SUM_W-1:0] w_pre_sum;
    logic             w_pre_sa;
    logic             w_pre_sb;
    logic             w_pre_sub;
    logic             w_pre_zero;
    logic             w_ss;

    // Output registers
    logic             r_out_valid;
    logic [SIG_W+3:0] r_fs;
    logic             r_fszero;
    logic             r_ss;

    // A stalled output freezes every stage, so in_ready follows it directly.
    assign w_stall  = r_out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    assign w_a_ext  = {2'b00, fa, 3'b000};
    assign w_b_ext  = {2'b00, fb};
    assign w_sum_in = sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

    // Stage 1: capture the raw two's-complement sum and the sign inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= {SUM_W{1'b0}};
            r_s1_sa    <= 1'b0;
            r_s1_sb    <= 1'b0;
            r_s1_sub   <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sum <= w_sum_in;
                r_s1_sa  <= sa;
                r_s1_sb  <= sb;
                r_s1_sub <= sub;
            end
        end
    end

`ifdef SIGADD_PIPE_ABS_STAGE_EN
    logic             r_s2_valid;
    logic [SUM_W-1:0] r_s2_sum;
    logic             r_s2_sa;
    logic             r_s2_sb;
    logic             r_s2_sub;

    // Extra stage: retime the sum ahead of the absolute-value logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_sum   <= {SUM_W{1'b0}};
            r_s2_sa    <= 1'b0;
            r_s2_sb    <= 1'b0;
            r_s2_sub   <= 1'b0;
        end else if (!w_stall) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sum <= r_s1_sum;
                r_s2_sa  <= r_s1_sa;
                r_s2_sb  <= r_s1_sb;
                r_s2_sub <= r_s1_sub;
            end
        end
    end

    assign w_pre_valid = r_s2_valid;
    assign w_pre_sum   = r_s2_sum;
    assign w_pre_sa    = r_s2_sa;
    assign w_pre_sb    = r_s2_sb;
    assign w_pre_sub   = r_s2_sub;
`else
    assign w_pre_valid = r_s1_valid;
    assign w_pre_sum   = r_s1_sum;
    assign w_pre_sa    = r_s1_sa;
    assign w_pre_sb    = r_s1_sb;
    assign w_pre_sub   = r_s1_sub;
`endif

    assign w_pre_zero = (w_pre_sum == {SUM_W{1'b0}});

    // Result sign: B's sign wins when B dominates. An exact zero is negative
    // only when two negative operands were truly added.
    always_comb begin
        w_ss = 1'b0;
        if (w_pre_zero) begin
            w_ss = w_pre_sa & ~w_pre_sub;
        end else if (w_pre_sum[SUM_W-1]) begin
            w_ss = w_pre_sb;
        end else begin
            w_ss = w_pre_sa;
        end
    end

    // Output stage: register the magnitude, zero flag and sign. The outputs
    // hold while stalled or when a bubble passes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_fs        <= {(SIG_W+4){1'b0}};
            r_fszero    <= 1'b0;
            r_ss        <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= w_pre_valid;
            if (w_pre_valid) begin
                r_fs     <= f_abs(w_pre_sum);
                r_fszero <= w_pre_zero;
                r_ss     <= w_ss;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign fs        = r_fs;
    assign fszero    = r_fszero;
    assign ss        = r_ss;

endmodule

// File: tb/tb_sigadd_pipe.sv
// -----------------------------------------------------------------------------
// tb_sigadd_pipe -- scoreboard bench for sigadd_pipe (SIG_W = 8).
// When an operand set is accepted, the expected result is computed with
// integer arithmetic and queued. A monitor pops the queue on every delivered
// result and also checks in_ready and output stability under backpressure.
// -----------------------------------------------------------------------------
module tb_sigadd_pipe;

    localparam int SIG_W = 8;
`ifdef SIGADD_PIPE_ABS_STAGE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [SIG_W-1:0] fa;
    logic [SIG_W+2:0] fb;
    logic             sa;
    logic             sb;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [SIG_W+3:0] fs;
    logic             fszero;
    logic             ss;

    sigadd_pipe #(.SIG_W(SIG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fa        (fa),
        .fb        (fb),
        .sa        (sa),
        .sb        (sb),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fs        (fs),
        .fszero    (fszero),
        .ss        (ss)
    );

    typedef struct {
        logic [SIG_W+3:0] fs;
        logic             z;
        logic             s;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   delivered = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain signed integer arithmetic on the operands.
    function automatic void push_op(input int unsigned a, input int unsigned b,
                                    input bit psa, input bit psb, input bit psub);
        longint s;
        longint m;
        exp_t   e;
        s = longint'(a) * 8 + (psub ? -longint'(b) : longint'(b));
        m = (s < 0) ? -s : s;
        e.fs = m[SIG_W+3:0];
        e.z  = (s == 0);
        if (s < 0)      e.s = psb;
        else if (s > 0) e.s = psa;
        else            e.s = psa & ~psub;
        q.push_back(e);
    endfunction

    // One cycle of stimulus, driven at the falling edge. acc reports whether
    // the rising edge that follows will accept the operands.
    task automatic drive_cycle(input bit v, input logic [SIG_W-1:0] a, input logic [SIG_W+2:0] b,
                               input bit psa, input bit psb, input bit psub, input bit ordy,
                               output bit acc);
        @(negedge clk);
        in_valid  = v;
        fa        = a;
        fb        = b;
        sa        = psa;
        sb        = psb;
        sub       = psub;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) push_op(a, b, psa, psb, psub);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 60 && q.size() != 0; i++)
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        repeat (4) drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        chk("drain_queue_empty", q.size(), 0);
    endtask

    // Monitor: sampled well after the falling edge, just before the next
    // rising edge, so the handshake values are the ones that edge will see.
    logic             prev_stall = 1'b0;
    logic             prev_rst   = 1'b1;
    logic [SIG_W+3:0] prev_fs    = '0;
    logic             prev_z     = 1'b0;
    logic             prev_s     = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        #3;
        chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
        if (prev_stall && !prev_rst) begin
            chk("hold_valid",  out_valid, 1);
            chk("hold_fs",     fs,        prev_fs);
            chk("hold_fszero", fszero,    prev_z);
            chk("hold_ss",     ss,        prev_s);
        end
        if (out_valid && out_ready && !rst) begin
            chk("result_expected", (q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                delivered++;
                chk("fs",     fs,     e.fs);
                chk("fszero", fszero, e.z);
                chk("ss",     ss,     e.s);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_rst   = rst;
        prev_fs    = fs;
        prev_z     = fszero;
        prev_s     = ss;
    end

    logic [SIG_W-1:0] bp_a [4];
    logic [SIG_W+2:0] bp_b [4];

    initial begin
        bit acc;
        int n;
        int idx;
        int d0;
        logic [SIG_W-1:0] ra;
        logic [SIG_W+2:0] rb;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        fa = '0; fb = '0; sa = 1'b0; sb = 1'b0; sub = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk); #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fs",        fs,        0);
        chk("rst_fszero",    fszero,    0);
        chk("rst_ss",        ss,        0);
        chk("rst_in_ready",  in_ready,  1);
        @(negedge clk);
        rst = 1'b0;

        // Plain add with latency measurement
        drive_cycle(1'b1, 8'hFF, 11'h7FF, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        chk("add_accepted", acc, 1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
            n++;
            #3;
            if (out_valid) break;
        end
        chk("latency", n, LAT);
        drain();

        // Negative difference and exact cancellations
        drive_cycle(1'b1, 8'h40, 11'h400, 1'b0, 1'b1, 1'b1, 1'b1, acc);
        drive_cycle(1'b1, 8'h80, 11'h400, 1'b1, 1'b0, 1'b1, 1'b1, acc);
        drive_cycle(1'b1, 8'h00, 11'h000, 1'b1, 1'b1, 1'b0, 1'b1, acc);
        drive_cycle(1'b1, 8'h00, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, acc);
        drive_cycle(1'b1, 8'h00, 11'h7FF, 1'b1, 1'b0, 1'b1, 1'b1, acc);
        drive_cycle(1'b1, 8'hFF, 11'h000, 1'b1, 1'b0, 1'b1, 1'b1, acc);
        drain();

        // Backpressure: four back-to-back operands, out_ready low in cycles 3-6
        bp_a[0] = 8'h11; bp_b[0] = 11'h123;
        bp_a[1] = 8'h22; bp_b[1] = 11'h456;
        bp_a[2] = 8'h33; bp_b[2] = 11'h789;
        bp_a[3] = 8'h44; bp_b[3] = 11'h7AB;
        idx = 0;
        d0  = delivered;
        for (int c = 1; c <= 14; c++) begin
            if (idx < 4)
                drive_cycle(1'b1, bp_a[idx], bp_b[idx], 1'b0, 1'b1, idx[0], !(c >= 3 && c <= 6), acc);
            else
                drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, !(c >= 3 && c <= 6), acc);
            if (acc) idx++;
            if (c >= 3 && c <= 6) chk("bp_in_ready_low", in_ready, 0);
        end
        chk("bp_all_issued", idx, 4);
        drain();
        chk("bp_delivered", delivered - d0, 4);

        // Reset with two operations in flight
        drive_cycle(1'b1, 8'h12, 11'h034, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        drive_cycle(1'b1, 8'h56, 11'h078, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
            #1;
            chk("flush_out_valid", out_valid, 0);
        end

        // Randomized traffic with random backpressure; operands offered while
        // in_ready is low must be ignored.
        for (int i = 0; i < 400; i++) begin
            ra = SIG_W'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? {ra, 3'b000} : (SIG_W+3)'($urandom_range(0, 2047));
            drive_cycle($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), 1'($urandom),
                        1'($urandom), $urandom_range(0, 3) != 0, acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
